addsub_seq_ctrl: RTL and testbench

//  Multi-precision add/subtract sequencer. One 8-bit add/sub slice with carry-in
//  is time-shared across WORDS byte lanes, so a 8*WORDS-bit A+/-B costs WORDS

---
 rtl/addsub_seq_ctrl_if.sv | 23 ++
 rtl/addsub_seq_ctrl.sv | 96 +++++++++
 tb/tb_addsub_seq_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_ctrl_if.sv
// Operand/result bundle for the multi-precision add/sub sequencer.
// Ovf is present only when OVF_DETECT_EN is defined.
interface addsub_seq_ctrl_if #(
    parameter int unsigned WORDS = 4
);
    logic               start;
    logic               sub;
    logic [8*WORDS-1:0] a;
    logic [8*WORDS-1:0] b;
    logic               busy;
    logic               done;
    logic [8*WORDS-1:0] s;
    logic               cout;
`ifdef OVF_DETECT_EN
    logic               ovf;

    modport master (output start, sub, a, b, input busy, done, s, cout, ovf);
    modport slave  (input start, sub, a, b, output busy, done, s, cout, ovf);
`else
    modport master (output start, sub, a, b, input busy, done, s, cout);
    modport slave  (input start, sub, a, b, output busy, done, s, cout);
`endif
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Multi-precision A+/-B using one 8-bit slice over WORDS byte lanes, LSB lane first.
// Optional two's-complement overflow output under OVF_DETECT_EN.
module addsub_seq_ctrl #(
    parameter int unsigned WORDS = 4
) (
    input logic               clk,
    input logic               rst_n,
    addsub_seq_ctrl_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(WORDS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q;
    logic                      carry_q;
    logic                      sub_q;
    logic [WORDS-1:0][7:0]     a_q;
    logic [WORDS-1:0][7:0]     bx_q;
    logic [WORDS-1:0][7:0]     s_q;
    logic                      cout_q;
    logic [8:0]                lane_sum;
    logic                      accept;
    logic                      last_lane;

    always_comb begin
        lane_sum  = {1'b0, a_q[idx_q]} + {1'b0, bx_q[idx_q]} + {8'b0, carry_q};
        last_lane = (idx_q == IdxW'(WORDS - 1));
        accept    = bus.start && (state_q == StIdle || state_q == StDone);
        state_d   = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (last_lane) state_d = StDone;
            StDone:  state_d = bus.start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            bx_q    <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            // Subtract as A + ~B + 1: the +1 rides in on the lane-0 carry.
            a_q     <= bus.a;
            bx_q    <= bus.sub ? ~bus.b : bus.b;
            sub_q   <= bus.sub;
            carry_q <= bus.sub;
            idx_q   <= '0;
        end else if (state_q == StRun) begin
            s_q[idx_q] <= lane_sum[7:0];
            carry_q    <= lane_sum[8];
            if (last_lane) begin
                cout_q <= lane_sum[8] ^ sub_q;
            end else begin
                idx_q <= idx_q + IdxW'(1);
            end
        end
    end

`ifdef OVF_DETECT_EN
    logic ovf_q;
    logic carry_into_msb;

    // Carry into bit W-1 recovered from the top lane's sum bit 7.
    assign carry_into_msb = lane_sum[7] ^ a_q[idx_q][7] ^ bx_q[idx_q][7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (!accept && state_q == StRun && last_lane) begin
            ovf_q <= lane_sum[8] ^ carry_into_msb;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Bench for addsub_seq_ctrl (WORDS=4): vector table, corner sequences, random vs model.
// Checks Ovf too when OVF_DETECT_EN is defined.
module tb_addsub_seq_ctrl;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 8 * WORDS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    addsub_seq_ctrl_if #(.WORDS(WORDS)) bus ();

    addsub_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_s;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, borrow and signed overflow from operand signs.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] s, output logic cout, output logic ovf);
        logic [W:0] full;
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
            s    = full[W-1:0];
            cout = (a < b);
            ovf  = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            s    = full[W-1:0];
            cout = full[W];
            ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
    endtask

    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Counts negedges until done (bounded); busy_n counts samples with busy high.
    task automatic wait_done(output int k, output int busy_n);
        k      = 0;
        busy_n = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (bus.busy) busy_n++;
            if (bus.done) break;
        end
        if (!bus.done) chk("done_timeout", 64'(k), 64'(WORDS + 1));
    endtask

    task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sub, input logic [W-1:0] exp_s,
                             input logic exp_cout, input logic exp_ovf);
        int k, busy_n;
        apply(a, b, sub);
        wait_done(k, busy_n);
        chk({name, "_latency"}, 64'(k), 64'(WORDS + 1));
        chk({name, "_busy_cycles"}, 64'(busy_n), 64'(WORDS));
        chk({name, "_s"}, 64'(bus.s), 64'(exp_s));
        chk({name, "_cout"}, 64'(bus.cout), 64'(exp_cout));
`ifdef OVF_DETECT_EN
        chk({name, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) chk({name, "_ovf_x"}, 64'(0), 64'(1));
`endif
    endtask

    initial begin
        vec_t vecs[8];
        int   k, busy_n, dn;
        logic [W-1:0] ra, rb, ms;
        logic rsub, mc, mo;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b0, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[7] = '{32'h0000_0003, 32'h0000_0001, 1'b1, 32'h0000_0002, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        chk("reset_s", 64'(bus.s), 64'd0);
        chk("reset_cout", 64'(bus.cout), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                      vecs[i].exp_s, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Start pulsed mid-RUN with other operands must be ignored.
        apply(32'h0000_0001, 32'h0000_0002, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h0000_0100;
        bus.b     = 32'h0000_0100;
        bus.sub   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(k, busy_n);
        chk("midrun_s", 64'(bus.s), 64'h3);
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("midrun_extra_done", 64'(dn), 64'd0);
        chk("midrun_s_hold", 64'(bus.s), 64'h3);

        // Start held through DONE: second op accepted with no IDLE gap.
        @(negedge clk);
        bus.a     = 32'h0000_1000;
        bus.b     = 32'h0000_0234;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a   = 32'h0000_0010;
        bus.b   = 32'h0000_0020;
        bus.sub = 1'b1;
        wait_done(k, busy_n);
        chk("b2b_first_s", 64'(bus.s), 64'h1234);
        @(negedge clk);
        chk("b2b_no_gap_busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done(k, busy_n);
        chk("b2b_second_latency", 64'(k), 64'(WORDS));
        chk("b2b_second_s", 64'(bus.s), 64'hFFFF_FFF0);
        chk("b2b_second_cout", 64'(bus.cout), 64'd1);

        // Asynchronous reset during lane 2, then a normal op.
        apply(32'h1234_5678, 32'h1111_1111, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_s", 64'(bus.s), 64'd0);
        chk("rst_mid_cout", 64'(bus.cout), 64'd0);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_done", 64'(bus.done), 64'd0);
`ifdef OVF_DETECT_EN
        chk("rst_mid_ovf", 64'(bus.ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_check("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rsub = 1'($urandom);
            if (i % 8 == 1) rb = ra;
            if (i % 8 == 3) ra = 32'h7FFF_FFFF ^ W'($urandom_range(0, 3));
            model(ra, rb, rsub, ms, mc, mo);
            run_check($sformatf("rand%0d", i), ra, rb, rsub, ms, mc, mo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
